// File: rtl/bram_address_sequencer_pkg.sv
// Shared types for the BRAM address sequencer.
// FSM state encoding, capture modes and end-of-frame helper.
package bram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    PENDING,
    WRITE
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SINGLE     = 2'd0;
  localparam mode_t MODE_CONTINUOUS = 2'd1;
  localparam mode_t MODE_FREE_RUN   = 2'd2;

  // Where a finished frame goes; reserved mode 3 acts as single-shot.
  function automatic state_t frame_end_state(input mode_t m);
    state_t s;
    case (m)
      MODE_CONTINUOUS: s = ARMED;
      MODE_FREE_RUN:   s = WRITE;
      default:         s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bram_address_sequencer_trig_edge_detect.sv
// Rising-edge detector for the capture trigger level.
// Previous level is registered; the edge itself is combinational.
module trig_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic in,
  output logic rise
);

  logic q;

  // Remember last cycle's level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) q <= 1'b0;
    else         q <= in;
  end

  assign rise = in & ~q;

endmodule

// File: rtl/bram_address_sequencer.sv
// BRAM port-A write-address sequencer for ADC capture frames.
// Optional trigger delay state enabled by defining TRIG_DELAY_EN.
module bram_address_sequencer
  import bram_seq_pkg::*;
#(
  parameter int COUNT_WIDTH = 13,
  parameter int ADDR_SHIFT  = 2,
  parameter int WEN_WIDTH   = 4,
  parameter int ACQ_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clken,
  input  logic                   trig,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [COUNT_WIDTH-1:0] count_max,
`ifdef TRIG_DELAY_EN
  input  logic [COUNT_WIDTH-1:0] trig_delay,
`endif
  output logic [31:0]            address,
  output logic [WEN_WIDTH-1:0]   wen,
  output logic                   busy,
  output logic                   done,
  output logic [ACQ_WIDTH-1:0]   acq_count
);

  logic [COUNT_WIDTH-1:0] count;
  logic [31:0]            count_ext;
  state_t                 state;
  logic                   wrap;
  logic                   trig_edge;
`ifdef TRIG_DELAY_EN
  logic [COUNT_WIDTH-1:0] dly_cnt;
`endif

  trig_edge_detect u_edge (
    .clk    (clk),
    .resetn (resetn),
    .in     (trig),
    .rise   (trig_edge)
  );

  assign wrap = clken & (count >= count_max);

  // Free-running word counter; >= lets a lowered count_max wrap at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    count <= '0;
    else if (clken) count <= wrap ? '0 : count + COUNT_WIDTH'(1);
  end

  // Frame FSM with done pulse and completed-frame counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      done      <= 1'b0;
      acq_count <= '0;
`ifdef TRIG_DELAY_EN
      dly_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (arm)
              state <= (mode == MODE_FREE_RUN) ? PENDING : ARMED;
          end
          ARMED: begin
            if (trig_edge) begin
`ifdef TRIG_DELAY_EN
              state   <= DELAY;
              dly_cnt <= trig_delay;
`else
              state   <= PENDING;
`endif
            end
          end
          DELAY: begin
`ifdef TRIG_DELAY_EN
            if (dly_cnt == '0) state <= PENDING;
            else if (clken)    dly_cnt <= dly_cnt - COUNT_WIDTH'(1);
`else
            state <= IDLE;
`endif
          end
          PENDING: begin
            if (wrap) state <= WRITE;
          end
          WRITE: begin
            if (wrap) begin
              done      <= 1'b1;
              acq_count <= acq_count + ACQ_WIDTH'(1);
              state     <= frame_end_state(mode);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign count_ext = 32'(count);
  assign address   = count_ext << ADDR_SHIFT;
  assign wen       = {WEN_WIDTH{state == WRITE}};
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_bram_address_sequencer.sv
// Directed self-checking bench for bram_address_sequencer.
// Inputs change and outputs are sampled on the falling edge.
module tb_bram_address_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        clken;
  logic        trig;
  logic        arm;
  logic        abort;
  logic [1:0]  mode;
  logic [12:0] count_max;
`ifdef TRIG_DELAY_EN
  logic [12:0] trig_delay;
`endif
  logic [31:0] address;
  logic [3:0]  wen;
  logic        busy;
  logic        done;
  logic [15:0] acq_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bram_address_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .clken      (clken),
    .trig       (trig),
    .arm        (arm),
    .abort      (abort),
    .mode       (mode),
    .count_max  (count_max),
`ifdef TRIG_DELAY_EN
    .trig_delay (trig_delay),
`endif
    .address    (address),
    .wen        (wen),
    .busy       (busy),
    .done       (done),
    .acq_count  (acq_count)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; clken = 1'b0; trig = 1'b0; arm = 1'b0;
    abort = 1'b0; mode = 2'd0; count_max = '0;
`ifdef TRIG_DELAY_EN
    trig_delay = '0;
`endif
    cyc(); cyc();
    chk("rst_address", address, 32'h0);
    chk("rst_wen", wen, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_acq", acq_count, 16'd0);
    resetn = 1'b1;
    cyc();

    // single-shot, count_max=7, trigger at count 3
    mode = 2'd0; count_max = 13'd7; clken = 1'b1; arm = 1'b1;
    cyc();
    chk("t1_armed_busy", busy, 1'b1);
    chk("t1_armed_addr", address, 32'h4);
    arm = 1'b0;
    cyc(); cyc();
    chk("t1_cnt3_addr", address, 32'hC);
    trig = 1'b1;
    cyc();
    chk("t1_pend_wen", wen, 4'h0);
    chk("t1_pend_busy", busy, 1'b1);
    trig = 1'b0;
    cyc(); cyc(); cyc();
    chk("t1_pre_wrap_wen", wen, 4'h0);
    cyc();
    chk("t1_w0_wen", wen, 4'hF);
    chk("t1_w0_addr", address, 32'h0);
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("t1_w_addr", address, 32'(i * 4));
      chk("t1_w_wen", wen, 4'hF);
      chk("t1_w_done", done, 1'b0);
    end
    cyc();
    chk("t1_done", done, 1'b1);
    chk("t1_acq", acq_count, 16'd1);
    chk("t1_end_wen", wen, 4'h0);
    chk("t1_end_busy", busy, 1'b0);
    cyc();
    chk("t1_done_pulse", done, 1'b0);

    // continuous, count_max=3, trigger every 12 cycles
    mode = 2'd1; count_max = 13'd3; arm = 1'b1;
    cyc();
    arm = 1'b0; trig = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      trig = 1'b0;
      chk("t2_pend_wen", wen, 4'h0);
      cyc();
      chk("t2_w0_wen", wen, 4'hF);
      chk("t2_w0_addr", address, 32'h0);
      cyc();
      chk("t2_w1_addr", address, 32'h4);
      trig = 1'b1;
      cyc();
      trig = 1'b0;
      chk("t2_w2_addr", address, 32'h8);
      cyc();
      chk("t2_w3_addr", address, 32'hC);
      chk("t2_w3_done", done, 1'b0);
      cyc();
      chk("t2_done", done, 1'b1);
      chk("t2_acq", acq_count, 32'(2 + k));
      chk("t2_rearm_busy", busy, 1'b1);
      chk("t2_rearm_wen", wen, 4'h0);
      repeat (6) cyc();
      chk("t2_ignored_trig_wen", wen, 4'h0);
      if (k < 2) trig = 1'b1;
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t2_abort_busy", busy, 1'b0);
    chk("t2_abort_acq", acq_count, 16'd4);

    // free-run, count_max=1
    mode = 2'd2; count_max = 13'd1; arm = 1'b1;
    cyc();
    arm = 1'b0;
    chk("t3_pend_busy", busy, 1'b1);
    chk("t3_pend_wen", wen, 4'h0);
    chk("t3_pend_addr", address, 32'h0);
    cyc();
    chk("t3_pend2_wen", wen, 4'h0);
    cyc();
    chk("t3_w0_wen", wen, 4'hF);
    chk("t3_w0_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_odd_addr", address, 32'h4);
      chk("t3_odd_done", done, 1'b0);
      chk("t3_odd_wen", wen, 4'hF);
      cyc();
      chk("t3_even_addr", address, 32'h0);
      chk("t3_even_done", done, 1'b1);
      chk("t3_even_wen", wen, 4'hF);
      chk("t3_acq", acq_count, 32'(5 + i));
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t3_abort_wen", wen, 4'h0);
    chk("t3_abort_done", done, 1'b0);
    chk("t3_abort_acq", acq_count, 16'd7);

    // clken gaps, count_max=4, single
    mode = 2'd0; count_max = 13'd4; arm = 1'b1;
    cyc();
    arm = 1'b0; trig = 1'b1;
    cyc();
    trig = 1'b0;
    cyc(); cyc();
    chk("t4_w0_wen", wen, 4'hF);
    chk("t4_w0_addr", address, 32'h0);
    for (int j = 1; j < 5; j++) begin
      clken = 1'b0;
      cyc();
      chk("t4_gap_addr", address, 32'((j - 1) * 4));
      chk("t4_gap_wen", wen, 4'hF);
      clken = 1'b1;
      cyc();
      chk("t4_adv_addr", address, 32'(j * 4));
      chk("t4_adv_done", done, 1'b0);
    end
    clken = 1'b0;
    cyc();
    chk("t4_last_gap_addr", address, 32'h10);
    chk("t4_last_gap_done", done, 1'b0);
    clken = 1'b1;
    cyc();
    chk("t4_done", done, 1'b1);
    chk("t4_end_wen", wen, 4'h0);
    chk("t4_acq", acq_count, 16'd8);

    // abort mid-frame at count 2
    arm = 1'b1;
    cyc();
    arm = 1'b0; trig = 1'b1;
    cyc();
    trig = 1'b0;
    cyc(); cyc(); cyc();
    chk("t5_w0_wen", wen, 4'hF);
    cyc(); cyc();
    chk("t5_w2_addr", address, 32'h8);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5_abort_wen", wen, 4'h0);
    chk("t5_abort_busy", busy, 1'b0);
    chk("t5_abort_done", done, 1'b0);
    chk("t5_abort_addr", address, 32'hC);
    cyc(); cyc();
    chk("t5_no_done", done, 1'b0);
    chk("t5_acq_kept", acq_count, 16'd8);

    // asynchronous reset mid-frame
    arm = 1'b1;
    cyc();
    arm = 1'b0; trig = 1'b1;
    cyc();
    trig = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("t5_pre_rst_wen", wen, 4'hF);
    chk("t5_pre_rst_addr", address, 32'h4);
    resetn = 1'b0;
    #1;
    chk("t5_rst_addr", address, 32'h0);
    chk("t5_rst_wen", wen, 4'h0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_acq", acq_count, 16'd0);
    clken = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();

`ifdef TRIG_DELAY_EN
    // trigger delay 10: PENDING lands just before the count_max=13 wrap
    mode = 2'd0; count_max = 13'd13; trig_delay = 13'd10;
    clken = 1'b1; arm = 1'b1;
    cyc();
    arm = 1'b0; trig = 1'b1;
    cyc();
    trig = 1'b0;
    repeat (11) cyc();
    chk("t6_dly_wen", wen, 4'h0);
    chk("t6_dly_busy", busy, 1'b1);
    cyc();
    chk("t6_dly_w0_wen", wen, 4'hF);
    chk("t6_dly_w0_addr", address, 32'h0);
    clken = 1'b0; resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
    // trigger delay 0: one cycle in DELAY
    count_max = 13'd3; trig_delay = 13'd0; clken = 1'b1; arm = 1'b1;
    cyc();
    arm = 1'b0; trig = 1'b1;
    cyc();
    trig = 1'b0;
    cyc();
    chk("t6_zero_pend_wen", wen, 4'h0);
    cyc();
    chk("t6_zero_w0_wen", wen, 4'hF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
